// File: rtl/jelly3_axi4_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : jelly3_axi4_burst_master
//  Description : AXI4 master issuing one INCR burst (read or write) per
//                command, with stream-side data and per-command status.
//  Revision    : 1.0 - initial release
// ============================================================================
module jelly3_axi4_burst_master #(
    parameter int                 ID_BITS   = 6,
    parameter int                 ADDR_BITS = 32,
    parameter int                 DATA_BITS = 32,
    parameter int                 STRB_BITS = DATA_BITS / 8,
    parameter int                 LEN_BITS  = 8,
    parameter logic [ID_BITS-1:0] AXI_ID    = '0
) (
    input  logic                 reset,
    input  logic                 clk,

    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [LEN_BITS-1:0]  cmd_len,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,

    input  logic [DATA_BITS-1:0] s_wdata,
    input  logic [STRB_BITS-1:0] s_wstrb,
    input  logic                 s_wvalid,
    output logic                 s_wready,

    output logic [DATA_BITS-1:0] m_rdata,
    output logic                 m_rlast,
    output logic                 m_rvalid,
    input  logic                 m_rready,

    output logic                 done,
    output logic [1:0]           done_resp,
    output logic                 busy,

    output logic [ID_BITS-1:0]   m_axi4_awid,
    output logic [ADDR_BITS-1:0] m_axi4_awaddr,
    output logic [LEN_BITS-1:0]  m_axi4_awlen,
    output logic [2:0]           m_axi4_awsize,
    output logic [1:0]           m_axi4_awburst,
    output logic                 m_axi4_awlock,
    output logic [3:0]           m_axi4_awcache,
    output logic [2:0]           m_axi4_awprot,
    output logic [3:0]           m_axi4_awqos,
    output logic                 m_axi4_awvalid,
    input  logic                 m_axi4_awready,
    output logic [DATA_BITS-1:0] m_axi4_wdata,
    output logic [STRB_BITS-1:0] m_axi4_wstrb,
    output logic                 m_axi4_wlast,
    output logic                 m_axi4_wvalid,
    input  logic                 m_axi4_wready,
    input  logic [ID_BITS-1:0]   m_axi4_bid,
    input  logic [1:0]           m_axi4_bresp,
    input  logic                 m_axi4_bvalid,
    output logic                 m_axi4_bready,

    output logic [ID_BITS-1:0]   m_axi4_arid,
    output logic [ADDR_BITS-1:0] m_axi4_araddr,
    output logic [LEN_BITS-1:0]  m_axi4_arlen,
    output logic [2:0]           m_axi4_arsize,
    output logic [1:0]           m_axi4_arburst,
    output logic                 m_axi4_arlock,
    output logic [3:0]           m_axi4_arcache,
    output logic [2:0]           m_axi4_arprot,
    output logic [3:0]           m_axi4_arqos,
    output logic                 m_axi4_arvalid,
    input  logic                 m_axi4_arready,
    input  logic [ID_BITS-1:0]   m_axi4_rid,
    input  logic [DATA_BITS-1:0] m_axi4_rdata,
    input  logic [1:0]           m_axi4_rresp,
    input  logic                 m_axi4_rlast,
    input  logic                 m_axi4_rvalid,
    output logic                 m_axi4_rready
);

    localparam int c_ALIGN  = $clog2(STRB_BITS);
    localparam int c_SPAN_W = LEN_BITS + c_ALIGN + 14;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_AW   = 3'd1;
    localparam logic [2:0] c_ST_W    = 3'd2;
    localparam logic [2:0] c_ST_B    = 3'd3;
    localparam logic [2:0] c_ST_AR   = 3'd4;
    localparam logic [2:0] c_ST_R    = 3'd5;

    logic [2:0]           r_state;
    logic [ADDR_BITS-1:0] r_addr;
    logic [LEN_BITS-1:0]  r_len;
    logic [LEN_BITS-1:0]  r_count;
    logic [1:0]           r_acc;
    logic                 r_done;
    logic [1:0]           r_done_resp;
    logic                 r_busy;

    logic [ADDR_BITS-1:0] w_addr_aligned;
    logic [c_SPAN_W-1:0]  w_span_end;
    logic                 w_4k_err;
    logic                 w_last;
    logic                 w_w_hs;
    logic                 w_r_hs;
    logic [1:0]           w_racc;

    assign w_addr_aligned = cmd_addr & ~ADDR_BITS'(STRB_BITS - 1);

    // Byte offset of the end of the burst within its 4KB page; must not exceed 4096
    assign w_span_end = c_SPAN_W'(w_addr_aligned[11:0])
                      + ((c_SPAN_W'(cmd_len) + c_SPAN_W'(1)) << c_ALIGN);
    assign w_4k_err   = (w_span_end > c_SPAN_W'(4096));

    assign w_last = (r_count == r_len);
    assign w_w_hs = (r_state == c_ST_W) && s_wvalid && m_axi4_wready;
    assign w_r_hs = (r_state == c_ST_R) && m_axi4_rvalid && m_rready;

    always_comb begin
        w_racc = (m_axi4_rresp > r_acc) ? m_axi4_rresp : r_acc;
        if ((m_axi4_rid != AXI_ID) || (m_axi4_rlast != w_last)) begin
            w_racc = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_acc       <= 2'b00;
            r_done      <= 1'b0;
            r_done_resp <= 2'b00;
            r_busy      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr  <= w_addr_aligned;
                        r_len   <= cmd_len;
                        r_count <= '0;
                        r_acc   <= 2'b00;
                        if (w_4k_err) begin
                            r_done      <= 1'b1;
                            r_done_resp <= 2'b10;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= cmd_write ? c_ST_AW : c_ST_AR;
                        end
                    end
                end
                c_ST_AW: begin
                    if (m_axi4_awready) begin
                        r_state <= c_ST_W;
                    end
                end
                c_ST_W: begin
                    if (w_w_hs) begin
                        if (w_last) begin
                            r_state <= c_ST_B;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                c_ST_B: begin
                    if (m_axi4_bvalid) begin
                        r_done      <= 1'b1;
                        r_done_resp <= (m_axi4_bid != AXI_ID) ? 2'b10 : m_axi4_bresp;
                        r_busy      <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                c_ST_AR: begin
                    if (m_axi4_arready) begin
                        r_state <= c_ST_R;
                    end
                end
                c_ST_R: begin
                    if (w_r_hs) begin
                        r_acc <= w_racc;
                        // Terminal compare precedes the increment so len = all-ones never wraps
                        if (w_last) begin
                            r_done      <= 1'b1;
                            r_done_resp <= w_racc;
                            r_busy      <= 1'b0;
                            r_state     <= c_ST_IDLE;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == c_ST_IDLE);
    assign done      = r_done;
    assign done_resp = r_done_resp;
    assign busy      = r_busy;

    assign m_axi4_awid    = AXI_ID;
    assign m_axi4_awaddr  = r_addr;
    assign m_axi4_awlen   = r_len;
    assign m_axi4_awsize  = 3'(c_ALIGN);
    assign m_axi4_awburst = 2'b01;
    assign m_axi4_awlock  = 1'b0;
    assign m_axi4_awcache = 4'b0011;
    assign m_axi4_awprot  = 3'b000;
    assign m_axi4_awqos   = 4'b0000;
    assign m_axi4_awvalid = (r_state == c_ST_AW);

    assign m_axi4_wdata  = s_wdata;
    assign m_axi4_wstrb  = s_wstrb;
    assign m_axi4_wlast  = (r_state == c_ST_W) && w_last;
    assign m_axi4_wvalid = (r_state == c_ST_W) && s_wvalid;
    assign s_wready      = (r_state == c_ST_W) && m_axi4_wready;
    assign m_axi4_bready = (r_state == c_ST_B);

    assign m_axi4_arid    = AXI_ID;
    assign m_axi4_araddr  = r_addr;
    assign m_axi4_arlen   = r_len;
    assign m_axi4_arsize  = 3'(c_ALIGN);
    assign m_axi4_arburst = 2'b01;
    assign m_axi4_arlock  = 1'b0;
    assign m_axi4_arcache = 4'b0011;
    assign m_axi4_arprot  = 3'b000;
    assign m_axi4_arqos   = 4'b0000;
    assign m_axi4_arvalid = (r_state == c_ST_AR);

    assign m_rdata       = m_axi4_rdata;
    assign m_rlast       = (r_state == c_ST_R) && w_last;
    assign m_rvalid      = (r_state == c_ST_R) && m_axi4_rvalid;
    assign m_axi4_rready = (r_state == c_ST_R) && m_rready;

endmodule
`default_nettype wire

// File: tb/tb_jelly3_axi4_burst_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_jelly3_axi4_burst_master
//  Description : Directed bench with a small AXI4 slave memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jelly3_axi4_burst_master;

    localparam int ID_BITS   = 6;
    localparam int ADDR_BITS = 32;
    localparam int DATA_BITS = 32;
    localparam int STRB_BITS = 4;
    localparam int LEN_BITS  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                 cmd_write, cmd_valid, cmd_ready;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [LEN_BITS-1:0]  cmd_len;
    logic [DATA_BITS-1:0] s_wdata;
    logic [STRB_BITS-1:0] s_wstrb;
    logic                 s_wvalid, s_wready;
    logic [DATA_BITS-1:0] m_rdata;
    logic                 m_rlast, m_rvalid, m_rready;
    logic                 done, busy;
    logic [1:0]           done_resp;

    logic [ID_BITS-1:0]   awid, bid, arid, rid;
    logic [ADDR_BITS-1:0] awaddr, araddr;
    logic [LEN_BITS-1:0]  awlen, arlen;
    logic [2:0]           awsize, arsize, awprot, arprot;
    logic [1:0]           awburst, arburst, bresp, rresp;
    logic                 awlock, arlock;
    logic [3:0]           awcache, arcache, awqos, arqos;
    logic                 awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic                 arvalid, arready, rlast, rvalid, rready;
    logic [DATA_BITS-1:0] wdata, rdata;
    logic [STRB_BITS-1:0] wstrb;

    jelly3_axi4_burst_master #(
        .ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
        .STRB_BITS(STRB_BITS), .LEN_BITS(LEN_BITS), .AXI_ID(6'd0)
    ) u_dut (
        .reset(reset), .clk(clk),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .done(done), .done_resp(done_resp), .busy(busy),
        .m_axi4_awid(awid), .m_axi4_awaddr(awaddr), .m_axi4_awlen(awlen),
        .m_axi4_awsize(awsize), .m_axi4_awburst(awburst), .m_axi4_awlock(awlock),
        .m_axi4_awcache(awcache), .m_axi4_awprot(awprot), .m_axi4_awqos(awqos),
        .m_axi4_awvalid(awvalid), .m_axi4_awready(awready),
        .m_axi4_wdata(wdata), .m_axi4_wstrb(wstrb), .m_axi4_wlast(wlast),
        .m_axi4_wvalid(wvalid), .m_axi4_wready(wready),
        .m_axi4_bid(bid), .m_axi4_bresp(bresp), .m_axi4_bvalid(bvalid), .m_axi4_bready(bready),
        .m_axi4_arid(arid), .m_axi4_araddr(araddr), .m_axi4_arlen(arlen),
        .m_axi4_arsize(arsize), .m_axi4_arburst(arburst), .m_axi4_arlock(arlock),
        .m_axi4_arcache(arcache), .m_axi4_arprot(arprot), .m_axi4_arqos(arqos),
        .m_axi4_arvalid(arvalid), .m_axi4_arready(arready),
        .m_axi4_rid(rid), .m_axi4_rdata(rdata), .m_axi4_rresp(rresp),
        .m_axi4_rlast(rlast), .m_axi4_rvalid(rvalid), .m_axi4_rready(rready)
    );

    // ---------------- slave memory model ----------------
    logic [31:0] mem [0:4095];
    logic        s_aw_have, s_b_pend, s_ar_have;
    logic [31:0] s_aw_addr, s_ar_addr;
    logic [7:0]  s_ar_len;
    int          s_wbeat, s_rbeat;
    int          w_rate    = 100;
    int          b_rate    = 100;
    logic [1:0]  inj_bresp = 2'b00;
    int          inj_rlast = -1;
    logic [11:0] w_idx, r_idx;

    assign w_idx   = s_aw_addr[13:2] + s_wbeat[11:0];
    assign r_idx   = s_ar_addr[13:2] + s_rbeat[11:0];
    assign awready = !s_aw_have;
    assign arready = !s_ar_have;
    assign bid     = '0;
    assign bresp   = inj_bresp;
    assign rid     = '0;
    assign rresp   = 2'b00;
    assign rvalid  = s_ar_have;
    assign rdata   = mem[r_idx];
    assign rlast   = s_ar_have && ((s_rbeat == int'(s_ar_len)) || (s_rbeat == inj_rlast));

    always @(posedge clk) begin
        if (reset) begin
            s_aw_have <= 1'b0;
            s_b_pend  <= 1'b0;
            s_ar_have <= 1'b0;
            bvalid    <= 1'b0;
            wready    <= 1'b0;
            s_wbeat   <= 0;
            s_rbeat   <= 0;
        end else begin
            wready <= ($urandom_range(0, 99) < w_rate);
            if (awvalid && awready) begin
                s_aw_have <= 1'b1;
                s_aw_addr <= awaddr;
                s_wbeat   <= 0;
            end
            if (wvalid && wready) begin
                for (int k = 0; k < 4; k++) begin
                    if (wstrb[k]) mem[w_idx][8*k +: 8] <= wdata[8*k +: 8];
                end
                s_wbeat <= s_wbeat + 1;
                if (wlast) s_b_pend <= 1'b1;
            end
            if (s_b_pend && !bvalid && ($urandom_range(0, 99) < b_rate)) bvalid <= 1'b1;
            if (bvalid && bready) begin
                bvalid    <= 1'b0;
                s_b_pend  <= 1'b0;
                s_aw_have <= 1'b0;
            end
            if (arvalid && arready) begin
                s_ar_have <= 1'b1;
                s_ar_addr <= araddr;
                s_ar_len  <= arlen;
                s_rbeat   <= 0;
            end
            if (rvalid && rready) begin
                s_rbeat <= s_rbeat + 1;
                if (s_rbeat == int'(s_ar_len)) s_ar_have <= 1'b0;
            end
        end
    end

    // ---------------- monitors (sampled at negedge) ----------------
    int          cyc = 0;
    int          done_cnt = 0, done_cyc = 0, acc_cyc = 0, avalid_cnt = 0;
    int          w_total = 0, rd_total = 0;
    logic [1:0]  last_resp;
    logic [31:0] aw_addr_q;
    logic [7:0]  aw_len_q;
    logic [2:0]  aw_size_q;
    logic [1:0]  aw_burst_q;
    logic [3:0]  aw_cache_q;
    logic        wlast_log [0:63];
    logic [31:0] rd_data_log [0:63];
    logic        rd_last_log [0:63];
    logic        rr_toggle = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    assign m_rready = rr_toggle ? cyc[0] : 1'b1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            last_resp = done_resp;
            done_cyc  = cyc;
        end
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (awvalid || arvalid) avalid_cnt++;
        if (awvalid && awready) begin
            aw_addr_q  = awaddr;
            aw_len_q   = awlen;
            aw_size_q  = awsize;
            aw_burst_q = awburst;
            aw_cache_q = awcache;
        end
        if (wvalid && wready && w_total < 64) begin
            wlast_log[w_total] = wlast;
            w_total++;
        end
        if (m_rvalid && m_rready && rd_total < 64) begin
            rd_data_log[rd_total] = m_rdata;
            rd_last_log[rd_total] = m_rlast;
            rd_total++;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [7:0] l);
        int k;
        @(posedge clk); #1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beats(input logic [31:0] base, input int n);
        int i = 0;
        int k = 0;
        while (i < n && k < 500) begin
            @(posedge clk); #1;
            s_wvalid = 1'b1;
            s_wdata  = base + i;
            s_wstrb  = 4'hF;
            @(negedge clk);
            if (s_wready) i++;
            k++;
        end
        @(posedge clk); #1;
        s_wvalid = 1'b0;
    endtask

    task automatic wait_done(input int prev, input string tag);
        int k = 0;
        while (done_cnt == prev && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        check(tag, done_cnt, prev + 1);
    endtask

    int         d0, w0, r0, a0;
    logic [3:0] mask;

    initial begin
        reset     = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_valid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {awvalid, wvalid, bready, arvalid, rready, m_rvalid, s_wready, done, busy}, 9'h0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_done_resp", done_resp, 2'b00);
        reset = 1'b0;

        // Write 0x1000 len 3 with 50% W/B readiness
        w_rate = 50; b_rate = 50;
        d0 = done_cnt; w0 = w_total;
        issue(1'b1, 32'h1000, 8'd3);
        send_beats(32'hA0, 4);
        wait_done(d0, "wr_done_count");
        check("wr_resp", last_resp, 2'b00);
        check("wr_awaddr", aw_addr_q, 32'h1000);
        check("wr_awlen", aw_len_q, 8'd3);
        check("wr_awsize", aw_size_q, 3'd2);
        check("wr_awburst_cache", {aw_burst_q, aw_cache_q}, {2'b01, 4'b0011});
        check("wr_beats", w_total - w0, 4);
        for (int i = 0; i < 4; i++) mask[i] = wlast_log[w0 + i];
        check("wr_wlast_pos", mask, 4'b1000);
        check("wr_busy_after", busy, 1'b0);
        w_rate = 100; b_rate = 100;

        // Read back with m_rready toggling
        rr_toggle = 1'b1;
        d0 = done_cnt; r0 = rd_total;
        issue(1'b0, 32'h1000, 8'd3);
        wait_done(d0, "rd_done_count");
        check("rd_resp", last_resp, 2'b00);
        check("rd_beats", rd_total - r0, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd_data%0d", i), rd_data_log[r0 + i], 32'hA0 + i);
            mask[i] = rd_last_log[r0 + i];
        end
        check("rd_rlast_pos", mask, 4'b1000);
        rr_toggle = 1'b0;

        // 4KB crossing: no address phase, done one cycle after acceptance
        d0 = done_cnt; a0 = avalid_cnt;
        issue(1'b1, 32'h0FF8, 8'd3);
        wait_done(d0, "4k_done_count");
        check("4k_resp", last_resp, 2'b10);
        check("4k_no_avalid", avalid_cnt - a0, 0);
        check("4k_latency", done_cyc - acc_cyc, 1);

        // len 0 unaligned write with SLVERR
        inj_bresp = 2'b10;
        d0 = done_cnt; w0 = w_total;
        issue(1'b1, 32'h2003, 8'd0);
        send_beats(32'h55, 1);
        wait_done(d0, "len0_done_count");
        inj_bresp = 2'b00;
        check("len0_awaddr", aw_addr_q, 32'h2000);
        check("len0_beats", w_total - w0, 1);
        check("len0_wlast", wlast_log[w0], 1'b1);
        check("len0_resp", last_resp, 2'b10);

        // Slave raises rlast early on beat 2
        inj_rlast = 1;
        d0 = done_cnt; r0 = rd_total;
        issue(1'b0, 32'h1000, 8'd3);
        wait_done(d0, "early_done_count");
        inj_rlast = -1;
        check("early_beats", rd_total - r0, 4);
        check("early_resp", last_resp, 2'b10);

        // Reset during W after first beat
        d0 = done_cnt; w0 = w_total;
        issue(1'b1, 32'h3000, 8'd3);
        begin
            int k = 0;
            while (w_total == w0 && k < 100) begin
                @(posedge clk); #1;
                s_wvalid = 1'b1;
                s_wdata  = 32'h77;
                s_wstrb  = 4'hF;
                @(negedge clk);
                k++;
            end
        end
        check("rst_mid_first_beat", w_total - w0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready, m_rvalid, s_wready, done, busy}, 9'h0);
        check("rst_mid_cmd_ready", cmd_ready, 1'b1);
        reset    = 1'b0;
        s_wvalid = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid_no_done", done_cnt, d0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jelly3_axi4_burst_master.md
Name: jelly3_axi4_burst_master

Overview:
Synthesizable AXI4 master that executes one single-burst read or write per command.
- Write data is taken from a stream input; read data is delivered on a stream output.
- Reports completion status per command.
- Drives flat AXI4 master ports. Used as the bus-side initiator for DMA-style engines, and as the stimulus end against the AXI4 slave memory model in benches.

Parameters:
ID_BITS, 6, AXI ID width
ADDR_BITS, 32, AXI address width
DATA_BITS, 32, AXI data width (power of 2, >=8)
STRB_BITS, DATA_BITS/8, strobe width
LEN_BITS, 8, AXI burst length width
AXI_ID, 0, constant value driven on awid/arid and expected on bid/rid

Ports:
reset  in  1  synchronous, active-high
clk  in  1  single clock; all ports sampled on rising edge
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_BITS  byte start address
cmd_len  in  LEN_BITS  beats-1
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept
s_wdata  in  DATA_BITS  write beat data
s_wstrb  in  STRB_BITS  write beat strobes
s_wvalid  in  1  write beat valid
s_wready  out  1  write beat accept
m_rdata  out  DATA_BITS  read beat data
m_rlast  out  1  last beat of read burst (internal count)
m_rvalid  out  1  read beat valid
m_rready  in  1  read beat accept
done  out  1  one-cycle completion pulse
done_resp  out  2  completion status
busy  out  1  command in progress
m_axi4_aw*/w*/b*/ar*/r*  AXI4 master ports: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid, awready, wdata, wstrb, wlast, wvalid, wready, bid, bresp, bvalid, bready; AR/R mirror, with rid, rdata, rresp, rlast. Widths per parameters.

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: state IDLE; awvalid, wvalid, bready, arvalid, rready, done, busy, m_rvalid, s_wready = 0; done_resp = 0; beat counter = 0.
- Reset mid-operation: immediate return to IDLE, all valids dropped. Acceptable only at system reset.
- FSM states: IDLE, AW, W, B, AR, R.
- IDLE:
  - cmd_ready = 1 only in IDLE.
  - On cmd_valid: latch write, len, and addr with the low $clog2(STRB_BITS) bits forced to 0; clear error accumulator.
  - 4KB check: if addr[11:0] + (len+1)*STRB_BITS > 4096, do not go to AW/AR. Next cycle, done=1 and done_resp=2'b10 with no bus activity.
  - Otherwise: busy=1; next state AW (write) or AR (read).
- Fixed address-channel fields: awsize/arsize = $clog2(STRB_BITS); burst = 2'b01 (INCR); lock = 0; cache = 4'b0011; prot = 0; qos = 0; id = AXI_ID.
- AW: awvalid held until the awready handshake; no field changes while valid; then W.
- W:
  - Combinational pass-through: wvalid = s_wvalid, s_wready = wready, wdata/wstrb = s_wdata/s_wstrb.
  - Beat counter increments per handshake; wlast = (count == len).
  - After the handshake with wlast: B.
  - s_wready = 0 outside W.
- B: bready = 1. On bvalid, capture bresp; if bid != AXI_ID, force resp 2'b10. Then done pulse, IDLE.
- AR: arvalid held until arready; then R.
- R:
  - Pass-through: m_rvalid = rvalid, rready = m_rready, m_rdata = rdata, m_rlast = (count == len).
  - Error accumulator per beat: max(acc, rresp); if rid != AXI_ID or rlast != (count == len), acc = 2'b10.
  - After the beat with count == len: done pulse with done_resp = acc, IDLE. Extra slave beats after that are not consumed (slave error).
- done: high exactly one cycle after the terminating handshake. busy drops in the same cycle as done. A new command may be accepted the cycle after done.
- Counter is LEN_BITS wide. len = 2^LEN_BITS-1 reaches its max without wrap because the terminal comparison precedes the increment.

Test Plan:
- Write 0x1000, len 3, data 0xA0..0xA3 against the slave model with W/B busy rates 50% -> awaddr 0x1000, awlen 3, awsize 2, 4 W beats with wlast only on the 4th; done once with resp 0.
- Read back 0x1000, len 3, m_rready toggling every cycle -> m_rdata 0xA0..0xA3 in order, m_rlast on the 4th beat only, done resp 0.
- cmd_addr 0x0FF8, len 3, DATA_BITS 32 -> no awvalid/arvalid ever asserted; done 1 cycle after acceptance, resp 2'b10.
- len 0 write at 0x2003 -> awaddr 0x2000, single beat with wlast=1; bresp SLVERR injected -> done_resp 2'b10.
- Read where the slave returns rlast on beat 2 of len 3 -> done after beat 4, resp 2'b10.
- reset asserted during W after beat 1 -> next cycle all valids 0, cmd_ready 1, no done pulse.
